// File: rtl/psram_ram_arb.sv
// psram_ram_arb: two-channel read arbiter in front of a single-port RAM with one-cycle read latency.
// Define PSRAM_RAM_ARB_PRIO_EN for fixed channel-0 priority; the default build arbitrates round-robin.
module psram_ram_arb #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              ch_start0,
    input  logic              ch_start1,
    input  logic [ADDR_W-1:0] cfg_base0,
    input  logic [ADDR_W-1:0] cfg_base1,
    input  logic [LEN_W-1:0]  cfg_len0,
    input  logic [LEN_W-1:0]  cfg_len1,
    input  logic              ram_rd_req0,
    input  logic              ram_rd_req1,
    output logic              ram_rd_ack0,
    output logic              ram_rd_ack1,
    output logic [31:0]       ram_rdata,
    output logic              ch_done0,
    output logic              ch_done1,
    output logic              ram_cs,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              grant_r;
    logic              grant_nxt_s;
    logic              win_s;
    logic              issue_s;
    logic              stale_r;
    logic              stale_nxt_s;
    logic [1:0]        start_s;
    logic [1:0]        req_s;
    logic [1:0]        elig_s;
    logic [1:0]        upd_s;
    logic [1:0]        active_r;
    logic [1:0]        ack_r;
    logic [1:0]        done_r;
    logic [ADDR_W-1:0] addr_r   [2];
    logic [LEN_W-1:0]  remain_r [2];
    logic [ADDR_W-1:0] base_s   [2];
    logic [LEN_W-1:0]  len_s    [2];
    logic              ram_cs_r;
    logic [ADDR_W-1:0] ram_addr_r;
`ifndef PSRAM_RAM_ARB_PRIO_EN
    logic              last_grant_r;
`endif

    assign start_s   = {ch_start1, ch_start0};
    assign req_s     = {ram_rd_req1, ram_rd_req0};
    assign base_s[0] = cfg_base0;
    assign base_s[1] = cfg_base1;
    assign len_s[0]  = cfg_len0;
    assign len_s[1]  = cfg_len1;
    assign elig_s    = req_s & active_r;

    // Pick the winning channel among the eligible ones
    always_comb begin
        win_s = 1'b0;
`ifdef PSRAM_RAM_ARB_PRIO_EN
        if (elig_s[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        if (elig_s == 2'b11) begin
            win_s = ~last_grant_r;
        end else if (elig_s[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // FSM next state; stale marks a reload that arrived after the grant was decided
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        stale_nxt_s = stale_r;
        issue_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (elig_s != 2'b00) begin
                    issue_s     = 1'b1;
                    grant_nxt_s = win_s;
                    stale_nxt_s = start_s[win_s];
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                stale_nxt_s = stale_r | start_s[grant_r];
                state_nxt_s = RESP;
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-word counter update for the granted channel when its word completes
    always_comb begin
        upd_s = 2'b00;
        if ((state_r == RESP) && !stale_r) begin
            upd_s[grant_r] = active_r[grant_r];
        end else begin
            upd_s = 2'b00;
        end
    end

    // FSM state, grant and stale registers
    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            stale_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            stale_r <= stale_nxt_s;
        end
    end

`ifndef PSRAM_RAM_ARB_PRIO_EN
    // Round-robin history, moves only when a grant is issued
    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            last_grant_r <= 1'b1;
        end else if (issue_s) begin
            last_grant_r <= win_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // RAM strobe/address and channel acks, one cycle each per grant
    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            ram_cs_r   <= 1'b0;
            ram_addr_r <= {ADDR_W{1'b0}};
            ack_r      <= 2'b00;
        end else begin
            ram_cs_r   <= issue_s;
            ram_addr_r <= issue_s ? addr_r[win_s] : {ADDR_W{1'b0}};
            if (state_r == ISSUE) begin
                ack_r <= grant_r ? 2'b10 : 2'b01;
            end else begin
                ack_r <= 2'b00;
            end
        end
    end

    // Channel counters; a start reload takes precedence over the per-word update
    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            for (int i = 0; i < 2; i++) begin
                addr_r[i]   <= {ADDR_W{1'b0}};
                remain_r[i] <= {LEN_W{1'b0}};
                active_r[i] <= 1'b0;
                done_r[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_s[i]) begin
                    addr_r[i]   <= base_s[i];
                    remain_r[i] <= len_s[i];
                    active_r[i] <= (len_s[i] != {LEN_W{1'b0}});
                    done_r[i]   <= (len_s[i] == {LEN_W{1'b0}});
                end else if (upd_s[i]) begin
                    addr_r[i]   <= addr_r[i] + ADDR_W'(1);
                    remain_r[i] <= remain_r[i] - LEN_W'(1);
                    active_r[i] <= (remain_r[i] != LEN_W'(1));
                    done_r[i]   <= (remain_r[i] == LEN_W'(1));
                end else begin
                    addr_r[i]   <= addr_r[i];
                    remain_r[i] <= remain_r[i];
                    active_r[i] <= active_r[i];
                    done_r[i]   <= 1'b0;
                end
            end
        end
    end

    assign ram_cs      = ram_cs_r;
    assign ram_addr    = ram_addr_r;
    assign ram_rd_ack0 = ack_r[0];
    assign ram_rd_ack1 = ack_r[1];
    assign ch_done0    = done_r[0];
    assign ch_done1    = done_r[1];
    // RAM data arrives the cycle after the strobe, which is exactly the ack cycle
    assign ram_rdata   = (ack_r != 2'b00) ? ram_dout : 32'd0;

endmodule

// File: tb/tb_psram_ram_arb.sv
// Self-checking bench for psram_ram_arb: event-schedule model compared every cycle plus directed literal checks.
module tb_psram_ram_arb;

    logic        hclk;
    logic        hrstn;
    logic        ch_start0, ch_start1;
    logic [9:0]  cfg_base0, cfg_base1;
    logic [9:0]  cfg_len0, cfg_len1;
    logic        ram_rd_req0, ram_rd_req1;
    logic        ram_rd_ack0, ram_rd_ack1;
    logic [31:0] ram_rdata;
    logic        ch_done0, ch_done1;
    logic        ram_cs;
    logic [9:0]  ram_addr;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    psram_ram_arb #(.ADDR_W(10), .LEN_W(10)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .ch_start0(ch_start0), .ch_start1(ch_start1),
        .cfg_base0(cfg_base0), .cfg_base1(cfg_base1),
        .cfg_len0(cfg_len0), .cfg_len1(cfg_len1),
        .ram_rd_req0(ram_rd_req0), .ram_rd_req1(ram_rd_req1),
        .ram_rd_ack0(ram_rd_ack0), .ram_rd_ack1(ram_rd_ack1),
        .ram_rdata(ram_rdata),
        .ch_done0(ch_done0), .ch_done1(ch_done1),
        .ram_cs(ram_cs), .ram_addr(ram_addr),
        .ram_dout(ram_dout)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hC0DE0000 | {22'd0, a};
    endfunction

    // RAM: data for the strobed address one cycle later, garbage otherwise
    always @(posedge hclk) ram_dout <= ram_cs ? mem_word(ram_addr) : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: schedule of expected output events per cycle ----------------
    int          cyc = 0;
    logic [9:0]  m_addr [2];
    logic [9:0]  m_rem  [2];
    bit          m_act  [2];
    int          gen    [2];
    int          m_last;
    int          free_from = 0;
    bit          upd_v = 1'b0;
    int          upd_at, upd_g, upd_gen;
    bit          e_cs   [8];
    logic [9:0]  e_addr [8];
    bit   [1:0]  e_ack  [8];
    logic [31:0] e_data [8];
    bit   [1:0]  e_done [8];

    task automatic model_step();
        int k, g, gen_pre;
        bit e0, e1, gr;
        bit [1:0] st;
        logic [9:0] a_pre;
        cyc++;
        k  = cyc;
        st = {ch_start1, ch_start0};
        if (!hrstn) begin
            for (int i = 0; i < 8; i++) begin
                e_cs[i] = 1'b0; e_addr[i] = 10'd0; e_ack[i] = 2'b00; e_data[i] = 32'd0; e_done[i] = 2'b00;
            end
            for (int i = 0; i < 2; i++) begin
                m_addr[i] = 10'd0; m_rem[i] = 10'd0; m_act[i] = 1'b0; gen[i] = 0;
            end
            m_last = 1; upd_v = 1'b0; free_from = k;
            return;
        end
        e0 = ram_rd_req0 && m_act[0];
        e1 = ram_rd_req1 && m_act[1];
        gr = (k - 1 >= free_from) && (e0 || e1);
        g = 0; a_pre = 10'd0; gen_pre = 0;
        if (gr) begin
`ifdef PSRAM_RAM_ARB_PRIO_EN
            g = e0 ? 0 : 1;
`else
            if (e0 && e1) g = (m_last == 1) ? 0 : 1;
            else g = e0 ? 0 : 1;
            m_last = g;
`endif
            a_pre   = m_addr[g];
            gen_pre = gen[g];
        end
        // a word retires only if its channel was not reloaded since the grant
        if (upd_v && upd_at == k) begin
            upd_v = 1'b0;
            if (gen[upd_g] == upd_gen && !st[upd_g]) begin
                m_addr[upd_g] = m_addr[upd_g] + 10'd1;
                m_rem[upd_g]  = m_rem[upd_g] - 10'd1;
                if (m_rem[upd_g] == 10'd0) begin
                    m_act[upd_g] = 1'b0;
                    e_done[k % 8][upd_g] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (st[i]) begin
                m_addr[i] = (i == 0) ? cfg_base0 : cfg_base1;
                m_rem[i]  = (i == 0) ? cfg_len0 : cfg_len1;
                m_act[i]  = (m_rem[i] != 10'd0);
                gen[i]++;
                if (m_rem[i] == 10'd0) e_done[k % 8][i] = 1'b1;
            end
        end
        if (gr) begin
            e_cs[k % 8]          = 1'b1;
            e_addr[k % 8]        = a_pre;
            e_ack[(k + 1) % 8][g] = 1'b1;
            e_data[(k + 1) % 8]  = mem_word(a_pre);
            upd_v = 1'b1; upd_at = k + 2; upd_g = g; upd_gen = gen_pre;
            free_from = k + 2;
        end
    endtask

    initial forever begin
        @(posedge hclk);
        model_step();
    end

    // ---------------- compare + observation logs ----------------
    logic [9:0]  addr_q[$];
    int          grant_q[$];
    logic [31:0] data_q[$];
    int          done_cnt0 = 0, done_cnt1 = 0;

    task automatic compare_step();
        int s;
        s = cyc % 8;
        chk("ram_cs",    {31'd0, ram_cs},      {31'd0, e_cs[s]});
        chk("ram_addr",  {22'd0, ram_addr},    e_cs[s] ? {22'd0, e_addr[s]} : 32'd0);
        chk("ack0",      {31'd0, ram_rd_ack0}, {31'd0, e_ack[s][0]});
        chk("ack1",      {31'd0, ram_rd_ack1}, {31'd0, e_ack[s][1]});
        chk("ram_rdata", ram_rdata,            (e_ack[s] != 2'b00) ? e_data[s] : 32'd0);
        chk("done0",     {31'd0, ch_done0},    {31'd0, e_done[s][0]});
        chk("done1",     {31'd0, ch_done1},    {31'd0, e_done[s][1]});
        chk("ack_excl",  {31'd0, ram_rd_ack0 & ram_rd_ack1}, 32'd0);
        if (ram_cs) addr_q.push_back(ram_addr);
        if (ram_rd_ack0) begin grant_q.push_back(0); data_q.push_back(ram_rdata); end
        if (ram_rd_ack1) begin grant_q.push_back(1); data_q.push_back(ram_rdata); end
        if (ch_done0) done_cnt0++;
        if (ch_done1) done_cnt1++;
        e_cs[s] = 1'b0; e_ack[s] = 2'b00; e_done[s] = 2'b00;
    endtask

    initial forever begin
        @(negedge hclk);
        if (cyc >= 1) compare_step();
    end

    // ---------------- directed stimulus ----------------
    logic [9:0] exp_aq[$];
    int         exp_gq[$];

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic clear_logs();
        addr_q.delete(); grant_q.delete(); data_q.delete();
        done_cnt0 = 0; done_cnt1 = 0;
    endtask

    task automatic start_ch(input int ch, input logic [9:0] base, input logic [9:0] len);
        if (ch == 0) begin cfg_base0 = base; cfg_len0 = len; ch_start0 = 1'b1; end
        else begin cfg_base1 = base; cfg_len1 = len; ch_start1 = 1'b1; end
        tick();
        ch_start0 = 1'b0; ch_start1 = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [1:0] mask, input int maxc);
        logic [1:0] seen;
        int n;
        seen = 2'b00; n = 0;
        while (seen != mask && n < maxc) begin
            tick();
            seen = seen | ({ch_done1, ch_done0} & mask);
            n++;
        end
        chk({name, "_done_timeout"}, {30'd0, seen}, {30'd0, mask});
    endtask

    task automatic wait_cs(input string name, input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ram_cs && n < maxc);
        chk({name, "_cs_timeout"}, {31'd0, ram_cs}, 32'd1);
    endtask

    task automatic do_reset();
        hrstn = 1'b0;
        tick();
        tick();
        hrstn = 1'b1;
    endtask

    task automatic cmp_addrs(input string name);
        chk({name, "_n"}, 32'(addr_q.size()), 32'(exp_aq.size()));
        for (int i = 0; i < exp_aq.size() && i < addr_q.size(); i++)
            chk(name, {22'd0, addr_q[i]}, {22'd0, exp_aq[i]});
    endtask

    initial begin
        hrstn = 1'b0; ch_start0 = 1'b0; ch_start1 = 1'b0;
        cfg_base0 = 10'd0; cfg_base1 = 10'd0; cfg_len0 = 10'd0; cfg_len1 = 10'd0;
        ram_rd_req0 = 1'b0; ram_rd_req1 = 1'b0;
        tick();
        tick();
        chk("rst_cs",    {31'd0, ram_cs}, 32'd0);
        chk("rst_addr",  {22'd0, ram_addr}, 32'd0);
        chk("rst_ack",   {30'd0, ram_rd_ack1, ram_rd_ack0}, 32'd0);
        chk("rst_rdata", ram_rdata, 32'd0);
        chk("rst_done",  {30'd0, ch_done1, ch_done0}, 32'd0);
        hrstn = 1'b1;
        tick();

        // ch0 alone, three words from 0x010
        clear_logs();
        start_ch(0, 10'h010, 10'd3);
        ram_rd_req0 = 1'b1;
        wait_done("t1", 2'b01, 40);
        ram_rd_req0 = 1'b0;
        tick();
        exp_aq = {10'h010, 10'h011, 10'h012};
        cmp_addrs("t1_addr");
        chk("t1_nack", 32'(data_q.size()), 32'd3);
        if (data_q.size() == 3) chk("t1_data2", data_q[2], 32'hC0DE0012);
        chk("t1_ndone", 32'(done_cnt0), 32'd1);

        // both channels, four words each, requests held
        do_reset();
        clear_logs();
        cfg_base0 = 10'h100; cfg_len0 = 10'd4; cfg_base1 = 10'h200; cfg_len1 = 10'd4;
        ch_start0 = 1'b1; ch_start1 = 1'b1;
        tick();
        ch_start0 = 1'b0; ch_start1 = 1'b0;
        ram_rd_req0 = 1'b1; ram_rd_req1 = 1'b1;
        wait_done("t2", 2'b11, 80);
        ram_rd_req0 = 1'b0; ram_rd_req1 = 1'b0;
        tick();
`ifdef PSRAM_RAM_ARB_PRIO_EN
        exp_gq = {0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_gq = {0, 1, 0, 1, 0, 1, 0, 1};
`endif
        chk("t2_nack", 32'(grant_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk("t2_grant", 32'(grant_q[i]), 32'(exp_gq[i]));

        // address wrap on ch1
        clear_logs();
        start_ch(1, 10'h3FE, 10'd3);
        ram_rd_req1 = 1'b1;
        wait_done("t3", 2'b10, 40);
        ram_rd_req1 = 1'b0;
        tick();
        exp_aq = {10'h3FE, 10'h3FF, 10'h000};
        cmp_addrs("t3_addr");

        // zero-length start: done only, no RAM access
        clear_logs();
        ram_rd_req0 = 1'b1;
        start_ch(0, 10'h055, 10'd0);
        tick();
        tick();
        tick();
        ram_rd_req0 = 1'b0;
        chk("t4_ncs", 32'(addr_q.size()), 32'd0);
        chk("t4_ndone", 32'(done_cnt0), 32'd1);

        // restart while the read is being issued
        clear_logs();
        start_ch(0, 10'h060, 10'd2);
        ram_rd_req0 = 1'b1;
        wait_cs("t5", 20);
        cfg_base0 = 10'h070; cfg_len0 = 10'd2; ch_start0 = 1'b1;
        tick();
        ch_start0 = 1'b0;
        wait_done("t5", 2'b01, 40);
        ram_rd_req0 = 1'b0;
        tick();
        exp_aq = {10'h060, 10'h070, 10'h071};
        cmp_addrs("t5_addr");
        chk("t5_ndone", 32'(done_cnt0), 32'd1);

        // restart during the response cycle
        clear_logs();
        start_ch(0, 10'h040, 10'd2);
        ram_rd_req0 = 1'b1;
        wait_cs("t6", 20);
        tick();
        cfg_base0 = 10'h050; cfg_len0 = 10'd1; ch_start0 = 1'b1;
        tick();
        ch_start0 = 1'b0;
        wait_done("t6", 2'b01, 40);
        ram_rd_req0 = 1'b0;
        tick();
        exp_aq = {10'h040, 10'h050};
        cmp_addrs("t6_addr");
        if (data_q.size() >= 1) chk("t6_data0", data_q[0], 32'hC0DE0040);
        chk("t6_ndone", 32'(done_cnt0), 32'd1);

        // reset while the read is being issued
        clear_logs();
        start_ch(0, 10'h020, 10'd2);
        ram_rd_req0 = 1'b1;
        wait_cs("t7", 20);
        hrstn = 1'b0;
        tick();
        chk("t7_cs",    {31'd0, ram_cs}, 32'd0);
        chk("t7_addr",  {22'd0, ram_addr}, 32'd0);
        chk("t7_ack",   {30'd0, ram_rd_ack1, ram_rd_ack0}, 32'd0);
        chk("t7_rdata", ram_rdata, 32'd0);
        hrstn = 1'b1;
        ram_rd_req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("t7_nack", 32'(grant_q.size()), 32'd0);
        chk("t7_ndone", 32'(done_cnt0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psram_ram_arb.md
PSRAM_RAM_ARB -- requirements
Module: psram_ram_arb

Interface
REQ-001 Parameter ADDR_W, default 10, sets the RAM word-address width.
REQ-002 Parameter LEN_W, default 10, sets the transfer word-count width.
REQ-003 Clocking: single clock hclk; reset hrstn, synchronous, active-low; no other clock or reset inputs.
REQ-004 hclk  input  1  sole clock; all logic on rising edge.
REQ-005 hrstn  input  1  synchronous active-low reset.
REQ-006 ch_start0 / ch_start1  input  1  load base and length for channel 0 / 1 (one-cycle pulse).
REQ-007 cfg_base0 / cfg_base1  input  ADDR_W  first word address for the channel; sampled on ch_start.
REQ-008 cfg_len0 / cfg_len1  input  LEN_W  word count for the channel; sampled on ch_start.
REQ-009 ram_rd_req0 / ram_rd_req1  input  1  level request from the channel's tx buffer; held until acked.
REQ-010 ram_rd_ack0 / ram_rd_ack1  output  1  one-cycle ack; ram_rdata is valid in the same cycle.
REQ-011 ram_rdata  output  32  shared read data to both channels.
REQ-012 ch_done0 / ch_done1  output  1  one-cycle pulse after the channel's last word is acked.
REQ-013 ram_cs  output  1  RAM read strobe.
REQ-014 ram_addr  output  ADDR_W  RAM read address; valid while ram_cs=1.
REQ-015 ram_dout  input  32  RAM data, valid exactly 1 cycle after ram_cs.

Function
REQ-016 Each channel SHALL hold addr_i, remain_i (LEN_W) and active_i; ch_start_i loads addr_i=cfg_base_i and remain_i=cfg_len_i, and sets active_i=(cfg_len_i!=0).
REQ-017 When ch_start_i carries cfg_len_i=0, ch_done_i SHALL pulse in the following cycle.
REQ-018 Channel i is eligible only when ram_rd_req_i=1 and active_i=1.
REQ-019 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-020 IDLE: if any channel is eligible, latch the grant and go to ISSUE; otherwise stay in IDLE.
REQ-021 ISSUE: assert ram_cs=1 with ram_addr=addr_g, then go to RESP.
REQ-022 RESP: assert ram_rd_ack_g=1 and ram_rdata=ram_dout, increment addr_g modulo 2^ADDR_W (wrap, no error), decrement remain_g, then go to IDLE.
REQ-023 Throughput is 1 word per 3 cycles; latency from an eligible request in IDLE to its ack is 2 cycles.
REQ-024 Default arbitration is round-robin: when both channels are eligible, grant the channel not granted last; last_grant updates only on a grant.
REQ-025 When remain_g goes 1->0 in RESP, clear active_g and pulse ch_done_g in the next cycle.
REQ-026 ram_rd_ack0 and ram_rd_ack1 SHALL never both be 1; each ack and ram_cs SHALL be at most one cycle long per grant.
REQ-027 ram_rdata SHALL be 0 in every cycle without an ack.
REQ-028 ch_start_i in the same cycle as RESP for channel i: the ack is still delivered, and the load from REQ-016 takes precedence over the increment/decrement.
REQ-029 ch_start_i while channel i is in ISSUE: the in-flight read completes at the old address; counters are reloaded from config.
REQ-030 A request that drops before its grant is ignored; a request cannot drop after its grant, per the handshake.

Reset
REQ-031 With hrstn=0 at a clock edge: FSM=IDLE, every active_i=0, addr_i=0, remain_i=0, last_grant=1 (so channel 0 wins first).
REQ-032 With hrstn=0 at a clock edge: ram_cs, ram_addr, every ack, ram_rdata and every ch_done SHALL be 0.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no ack and no done pulse.

Configuration
REQ-034 Macro PSRAM_RAM_ARB_PRIO_EN defined: fixed priority, channel 0 always wins when both are eligible; last_grant is unused.
REQ-035 Macro PSRAM_RAM_ARB_PRIO_EN undefined: round-robin per REQ-024.

Verification
REQ-036 Ch0 alone: start, base=0x010, len=3 -> ram_addr 0x010, 0x011, 0x012; 3 acks carrying RAM data; ch_done0 pulses once, 1 cycle after the 3rd ack.
REQ-037 Both channels requesting continuously, len=4 each, macro undefined -> grants 0,1,0,1,0,1,0,1; never two acks in one cycle.
REQ-038 Same stimulus with PSRAM_RAM_ARB_PRIO_EN -> four ch0 acks first, then four ch1 acks.
REQ-039 base=0x3FE (ADDR_W=10), len=3 -> ram_addr 0x3FE, 0x3FF, 0x000.
REQ-040 len=0 start -> done pulse next cycle, no ram_cs; hrstn=0 during ISSUE -> no ack, all outputs 0 the next cycle.
